// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: load handshake, bit-strobed shift, RX word capture, abort.
// First bit on serial_out the cycle after load; rx_valid one cycle after the final strobe; load_ready only when idle.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 1,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  spi_clk,
  input  logic                  spi_rst,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  shift_en,
  input  logic                  abort,
  input  logic                  serial_in,
  output logic                  serial_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      bit_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  logic                  accept;
  logic                  step;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] shifted;

  // Abort outranks both a load and a strobe, including the final bit.
  assign accept   = (state_q == IDLE) && load_valid && !abort;
  assign step     = (state_q == SHIFT) && shift_en && !abort;
  assign last_bit = step && (cnt_q == CNT_LAST);

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (abort || last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q == SHIFT);
    serial_out = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
    rx_data    = rx_data_q;
    rx_valid   = rx_valid_q;
    bit_cnt    = cnt_q;
  end

  always_comb begin
    shifted = shift_q;
    if (MSB_FIRST != 0) begin
      shifted = {shift_q[DATA_WIDTH-2:0], serial_in};
    end else begin
      shifted = {serial_in, shift_q[DATA_WIDTH-1:1]};
    end
  end

  // The shift register is cleared on abort so an idle engine drives 0.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (accept) begin
      shift_d = load_data;
      cnt_d   = '0;
    end else if ((state_q == SHIFT) && abort) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (step) begin
      shift_d = shifted;
      if (last_bit) begin
        cnt_d      = '0;
        rx_data_d  = shifted;
        rx_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: four instances cover MSB/LSB order and widths 2, 8, 16.
module tb_spi_shift_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: 8-bit MSB-first, loopback
  logic       a_lv, a_lr, a_se, a_ab, a_sin, a_sout, a_rxv, a_busy;
  logic [7:0] a_ld, a_rxd;
  logic [3:0] a_cnt;
  assign a_sin = a_sout;
  spi_shift_engine #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_a (
    .spi_clk(clk), .spi_rst(rst), .load_valid(a_lv), .load_data(a_ld), .load_ready(a_lr),
    .shift_en(a_se), .abort(a_ab), .serial_in(a_sin), .serial_out(a_sout),
    .rx_data(a_rxd), .rx_valid(a_rxv), .busy(a_busy), .bit_cnt(a_cnt));

  // Instance B: 8-bit LSB-first, external serial_in
  logic       b_lv, b_lr, b_se, b_ab, b_sin, b_sout, b_rxv, b_busy;
  logic [7:0] b_ld, b_rxd;
  logic [3:0] b_cnt;
  spi_shift_engine #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_b (
    .spi_clk(clk), .spi_rst(rst), .load_valid(b_lv), .load_data(b_ld), .load_ready(b_lr),
    .shift_en(b_se), .abort(b_ab), .serial_in(b_sin), .serial_out(b_sout),
    .rx_data(b_rxd), .rx_valid(b_rxv), .busy(b_busy), .bit_cnt(b_cnt));

  // Instance C: 2-bit MSB-first, loopback
  logic       c_lv, c_lr, c_se, c_ab, c_sin, c_sout, c_rxv, c_busy;
  logic [1:0] c_ld, c_rxd;
  logic [1:0] c_cnt;
  assign c_sin = c_sout;
  spi_shift_engine #(.DATA_WIDTH(2), .MSB_FIRST(1)) u_c (
    .spi_clk(clk), .spi_rst(rst), .load_valid(c_lv), .load_data(c_ld), .load_ready(c_lr),
    .shift_en(c_se), .abort(c_ab), .serial_in(c_sin), .serial_out(c_sout),
    .rx_data(c_rxd), .rx_valid(c_rxv), .busy(c_busy), .bit_cnt(c_cnt));

  // Instance D: 16-bit LSB-first, loopback
  logic        d_lv, d_lr, d_se, d_ab, d_sin, d_sout, d_rxv, d_busy;
  logic [15:0] d_ld, d_rxd;
  logic [4:0]  d_cnt;
  assign d_sin = d_sout;
  spi_shift_engine #(.DATA_WIDTH(16), .MSB_FIRST(0)) u_d (
    .spi_clk(clk), .spi_rst(rst), .load_valid(d_lv), .load_data(d_ld), .load_ready(d_lr),
    .shift_en(d_se), .abort(d_ab), .serial_in(d_sin), .serial_out(d_sout),
    .rx_data(d_rxd), .rx_valid(d_rxv), .busy(d_busy), .bit_cnt(d_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  exp8;
    logic [7:0]  sin8;
    logic [15:0] w16;
    logic [1:0]  w2;
    int          peak;

    a_lv = 0; a_ld = '0; a_se = 0; a_ab = 0;
    b_lv = 0; b_ld = '0; b_se = 0; b_ab = 0; b_sin = 0;
    c_lv = 0; c_ld = '0; c_se = 0; c_ab = 0;
    d_lv = 0; d_ld = '0; d_se = 0; d_ab = 0;
    tick(); tick();
    rst = 0;
    tick();

    // Reset in the middle of a transfer at bit_cnt = 3
    a_ld = 8'hFF; a_lv = 1;
    tick();
    a_lv = 0;
    chk("busy_after_load", 32'(a_busy), 32'd1);
    a_se = 1;
    tick(); tick(); tick();
    a_se = 0;
    chk("cnt_before_reset", 32'(a_cnt), 32'd3);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_load_ready", 32'(a_lr), 32'd1);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_serial_out", 32'(a_sout), 32'd0);
    chk("rst_rx_valid", 32'(a_rxv), 32'd0);
    chk("rst_rx_data", 32'(a_rxd), 32'd0);

    // Loopback 0xA5 MSB-first, 8 consecutive strobes
    exp8 = 8'hA5;
    a_ld = 8'hA5; a_lv = 1;
    tick();
    a_lv = 0;
    chk("lb_busy", 32'(a_busy), 32'd1);
    chk("lb_load_ready", 32'(a_lr), 32'd0);
    a_se = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lb_sout_%0d", i), 32'(a_sout), 32'(exp8[7-i]));
      chk($sformatf("lb_cnt_%0d", i), 32'(a_cnt), 32'(i));
      chk($sformatf("lb_rxv_%0d", i), 32'(a_rxv), 32'd0);
      tick();
    end
    a_se = 0;
    chk("lb_rx_valid", 32'(a_rxv), 32'd1);
    chk("lb_rx_data", 32'(a_rxd), 32'hA5);
    chk("lb_done_ready", 32'(a_lr), 32'd1);
    chk("lb_done_busy", 32'(a_busy), 32'd0);
    chk("lb_done_cnt", 32'(a_cnt), 32'd0);
    tick();
    chk("lb_rxv_one_cycle", 32'(a_rxv), 32'd0);
    chk("lb_rxd_held", 32'(a_rxd), 32'hA5);

    // Abort together with the 6th strobe, load held alongside abort
    a_ld = 8'hFF; a_lv = 1;
    tick();
    a_lv = 0; a_se = 1;
    repeat (5) tick();
    chk("ab_cnt5", 32'(a_cnt), 32'd5);
    a_ab = 1; a_lv = 1; a_ld = 8'h12;
    tick();
    chk("ab_busy", 32'(a_busy), 32'd0);
    chk("ab_ready", 32'(a_lr), 32'd1);
    chk("ab_cnt", 32'(a_cnt), 32'd0);
    chk("ab_rxv", 32'(a_rxv), 32'd0);
    chk("ab_rxd_kept", 32'(a_rxd), 32'hA5);
    chk("ab_sout_zero", 32'(a_sout), 32'd0);
    a_se = 0;
    tick();
    chk("ab_load_blocked", 32'(a_busy), 32'd0);
    chk("ab_sout_still0", 32'(a_sout), 32'd0);
    a_ab = 0; a_lv = 0;

    // Strobes while idle are ignored
    a_se = 1;
    repeat (3) tick();
    chk("idle_se_busy", 32'(a_busy), 32'd0);
    chk("idle_se_cnt", 32'(a_cnt), 32'd0);
    chk("idle_se_rxv", 32'(a_rxv), 32'd0);
    chk("idle_se_rxd", 32'(a_rxd), 32'hA5);

    // Back-to-back 0x81 then 0x7E with strobe held high throughout
    a_ld = 8'h81; a_lv = 1;
    tick();
    a_lv = 0;
    chk("b2b_first_cnt", 32'(a_cnt), 32'd0);
    repeat (8) tick();
    chk("b2b_rxv1", 32'(a_rxv), 32'd1);
    chk("b2b_rxd1", 32'(a_rxd), 32'h81);
    chk("b2b_ready1", 32'(a_lr), 32'd1);
    a_ld = 8'h7E; a_lv = 1;
    tick();
    a_lv = 0;
    chk("b2b_reload_busy", 32'(a_busy), 32'd1);
    chk("b2b_gap_rxv", 32'(a_rxv), 32'd0);
    chk("b2b_reload_sout", 32'(a_sout), 32'd0);
    chk("b2b_reload_cnt", 32'(a_cnt), 32'd0);
    repeat (7) tick();
    chk("b2b_cnt7", 32'(a_cnt), 32'd7);
    tick();
    a_se = 0;
    chk("b2b_rxv2", 32'(a_rxv), 32'd1);
    chk("b2b_rxd2", 32'(a_rxd), 32'h7E);
    tick();
    chk("b2b_rxv2_end", 32'(a_rxv), 32'd0);

    // LSB-first external RX with 3-cycle gaps between strobes
    exp8 = 8'h3C;
    sin8 = 8'h53;
    b_ld = 8'h3C; b_lv = 1;
    tick();
    b_lv = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_sout_%0d", i), 32'(b_sout), 32'(exp8[i]));
      b_sin = sin8[i]; b_se = 1;
      tick();
      b_se = 0;
      if (i < 7) begin
        for (int g = 0; g < 3; g++) begin
          chk($sformatf("lsb_gap_cnt_%0d_%0d", i, g), 32'(b_cnt), 32'(i + 1));
          tick();
        end
      end
    end
    chk("lsb_rxv", 32'(b_rxv), 32'd1);
    chk("lsb_rxd", 32'(b_rxd), 32'h53);
    chk("lsb_busy", 32'(b_busy), 32'd0);
    chk("lsb_cnt", 32'(b_cnt), 32'd0);

    // Width sweep: 2-bit and 16-bit loopback with random words
    for (int k = 0; k < 3; k++) begin
      w2 = 2'($urandom);
      c_ld = w2; c_lv = 1;
      tick();
      c_lv = 0; c_se = 1; peak = 0;
      for (int i = 0; i < 2; i++) begin
        if (int'(c_cnt) > peak) peak = int'(c_cnt);
        tick();
      end
      c_se = 0;
      chk($sformatf("w2_rxv_%0d", k), 32'(c_rxv), 32'd1);
      chk($sformatf("w2_rxd_%0d", k), 32'(c_rxd), 32'(w2));
      chk($sformatf("w2_peak_%0d", k), 32'(peak), 32'd1);
      tick();

      w16 = 16'($urandom);
      d_ld = w16; d_lv = 1;
      tick();
      d_lv = 0; d_se = 1; peak = 0;
      for (int i = 0; i < 16; i++) begin
        if (int'(d_cnt) > peak) peak = int'(d_cnt);
        tick();
      end
      d_se = 0;
      chk($sformatf("w16_rxv_%0d", k), 32'(d_rxv), 32'd1);
      chk($sformatf("w16_rxd_%0d", k), 32'(d_rxd), 32'(w16));
      chk($sformatf("w16_peak_%0d", k), 32'(peak), 32'd15);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised full-duplex SPI shift engine: the next generation of the SPI shift register, generalised in word width and bit order. It adds a load handshake, bit counting, serial capture, transfer completion and abort. It sits between the SPI clock/chip-select sequencer, which supplies bit strobes and abort, and the word-level TX/RX logic.

## Interface
- `DATA_WIDTH`, default 8: word width in bits; legal range >= 2.
- `MSB_FIRST`, default 1: bit order. 1 means bit `DATA_WIDTH-1` is shifted out first. 0 means bit 0 is shifted out first.
- `CNT_W`, default `$clog2(DATA_WIDTH+1)`: width of `bit_cnt`. Derived; do not override.

Ports:
- `spi_clk`  in  1  single clock; all logic on its rising edge.
- `spi_rst`  in  1  reset; synchronous, active-high.
- `load_valid`  in  1  request to load `load_data` and start a transfer.
- `load_data`  in  DATA_WIDTH  TX word.
- `load_ready`  out  1  engine idle; a load is accepted this cycle.
- `shift_en`  in  1  one-cycle bit strobe from the sequencer.
- `abort`  in  1  chip-select release; kills any transfer in progress.
- `serial_in`  in  1  MISO/MOSI input bit; sampled on `shift_en`.
- `serial_out`  out  1  current outgoing bit.
- `rx_data`  out  DATA_WIDTH  last completed RX word; held until the next completion.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  transfer in progress.
- `bit_cnt`  out  CNT_W  bits shifted so far in the current transfer.

## Operation
- State machine: `IDLE` and `SHIFT`. `load_ready` = (state == `IDLE`); `busy` = (state == `SHIFT`). Both are registered state decodes.
- Load handshake: a load is accepted when `load_valid & load_ready & ~abort`. On acceptance:
  - `shift_reg` <= `load_data`, `bit_cnt` <= 0, state -> `SHIFT`.
  - `load_valid` with `abort` high is ignored.
- `serial_out` is combinational from `shift_reg`: `shift_reg[DATA_WIDTH-1]` when `MSB_FIRST`=1, `shift_reg[0]` when `MSB_FIRST`=0. In `IDLE` it shows the retained register, which is 0 after reset or abort.
- Shift in `SHIFT` with `shift_en` high and `abort` low:
  - `MSB_FIRST`=1: `shift_reg` <= {`shift_reg[DATA_WIDTH-2:0]`, `serial_in`}.
  - `MSB_FIRST`=0: `shift_reg` <= {`serial_in`, `shift_reg[DATA_WIDTH-1:1]`}.
  - `bit_cnt` increments by 1.
- Completion happens on the shift where `bit_cnt == DATA_WIDTH-1`:
  - `rx_data` <= the new shift value.
  - `rx_valid` <= 1 for one cycle.
  - `bit_cnt` <= 0, state -> `IDLE`.
- `shift_en` is ignored in `IDLE`. Gaps between strobes of any length are legal; state and count hold.
- Abort:
  - In `SHIFT`: next cycle is `IDLE`, `shift_reg` = 0, `bit_cnt` = 0, no `rx_valid`, `rx_data` unchanged.
  - Abort outranks `shift_en`, including on the final bit.
  - In `IDLE`: no effect except blocking a load.
- `bit_cnt` never exceeds `DATA_WIDTH-1` in `SHIFT`; there is no wrap.

## Timing
- Reset (`spi_rst` high at an edge) values on the next cycle:
  - state `IDLE`, `shift_reg` 0, `bit_cnt` 0, `rx_data` 0, `rx_valid` 0.
  - Therefore `load_ready` 1, `busy` 0, `serial_out` 0.
  - Reset outranks every other input, including mid-transfer.
- Load accepted at edge N: the first bit appears on `serial_out` after N, and `busy` is 1 from N.
- Final `shift_en` at edge M: `rx_valid` and the new `rx_data` are visible after M, and `load_ready` is 1 in the same cycle.
- Minimum transfer: 1 load cycle + `DATA_WIDTH` strobe cycles.
- Back-to-back: a load is accepted in the `rx_valid` cycle, so the bubble between words is 0 cycles.
- `rx_valid` is high for exactly one cycle per completed word, never two in consecutive cycles. Worst case is `DATA_WIDTH`+1 cycles between pulses.

## Test plan
- Reset: assert `spi_rst` mid-transfer (`bit_cnt`=3) -> next cycle `busy`=0, `load_ready`=1, `bit_cnt`=0, `serial_out`=0, `rx_valid`=0, `rx_data`=0.
- Loopback, `DATA_WIDTH`=8, `MSB_FIRST`=1: `serial_in` tied to `serial_out`, load 0xA5, 8 consecutive strobes -> `serial_out` sequence 1,0,1,0,0,1,0,1; `rx_valid` pulse with `rx_data`=0xA5.
- LSB-first external RX, `MSB_FIRST`=0: load 0x3C, `serial_in` sequence 1,1,0,0,1,0,1,0 with strobes separated by 3-cycle gaps -> `serial_out` sequence 0,0,1,1,1,1,0,0; `rx_data`=0x53; `bit_cnt` holds during gaps.
- Abort: load 0xFF, 5 strobes, then `abort` together with a strobe -> next cycle `IDLE`, `bit_cnt`=0, no `rx_valid`, previous `rx_data` retained. A `load_valid` held with `abort` is not accepted.
- Back-to-back plus ignored strobes: `shift_en` pulses while `IDLE` change nothing. Load 0x81, complete, reload 0x7E in the `rx_valid` cycle -> second transfer starts with 0 bubble, two separate one-cycle `rx_valid` pulses.
- Width sweep: `DATA_WIDTH`=2 and 16 with random words and loopback -> `rx_data` equals the loaded word and `bit_cnt` peaks at `DATA_WIDTH`-1.
